// File: rtl/lockin_measurement_sequencer.sv
// Runs one lock-in measurement: clears the datapath, streams until N_RES
// results are summed, publishes the sums, and flags a stall as an error.
module lockin_measurement_sequencer #(
    parameter int Q_IN         = 50,
    parameter int N_RES        = 4,
    parameter int LOG2_N_RES   = 2,
    parameter int CLEAR_CYCLES = 4,
    parameter int TIMEOUT      = 1048576,
    parameter int TIMEOUT_W    = 21
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         li_valid,
    input  logic [Q_IN-1:0]              li_fase,
    input  logic [Q_IN-1:0]              li_cuad,
    output logic                         enable_out,
    output logic                         clear_out,
    output logic [Q_IN+LOG2_N_RES-1:0]   res_fase,
    output logic [Q_IN+LOG2_N_RES-1:0]   res_cuad,
    output logic                         res_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam int ACC_W      = Q_IN + LOG2_N_RES;
    localparam int CNT_W      = LOG2_N_RES + 1;
    localparam int CLR_W      = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int TMO_LAST_I = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;

    localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(N_RES - 1);
    localparam logic [CLR_W-1:0]     CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST  = TIMEOUT_W'(TMO_LAST_I);
    localparam bit                   TMO_ALWAYS = (TIMEOUT <= 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_W-1:0]       acc_fase_q, acc_fase_d;
    logic [ACC_W-1:0]       acc_cuad_q, acc_cuad_d;
    logic [ACC_W-1:0]       res_fase_q, res_fase_d;
    logic [ACC_W-1:0]       res_cuad_q, res_cuad_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
    logic                   res_valid_q, res_valid_d;
    logic                   enable_q, enable_d;
    logic                   clear_q, clear_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic [ACC_W-1:0]       fase_ext;
    logic [ACC_W-1:0]       cuad_ext;
    logic                   tmo_expired;

    assign fase_ext = ACC_W'($signed(li_fase));
    assign cuad_ext = ACC_W'($signed(li_cuad));

    // Expiry is the idle cycle on which the gap counter would reach TIMEOUT-1.
    assign tmo_expired = TMO_ALWAYS || (tmo_q >= TMO_LAST);

    always_comb begin
        state_d     = state_q;
        acc_fase_d  = acc_fase_q;
        acc_cuad_d  = acc_cuad_q;
        res_fase_d  = res_fase_q;
        res_cuad_d  = res_cuad_q;
        cnt_d       = cnt_q;
        clr_cnt_d   = clr_cnt_q;
        tmo_d       = tmo_q;
        res_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!abort && start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end

            ST_CLEAR: begin
                acc_fase_d = '0;
                acc_cuad_d = '0;
                cnt_d      = '0;
                tmo_d      = '0;
                if (abort) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == CLR_LAST) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (li_valid) begin
                    acc_fase_d = acc_fase_q + fase_ext;
                    acc_cuad_d = acc_cuad_q + cuad_ext;
                    cnt_d      = cnt_q + CNT_W'(1);
                    tmo_d      = '0;
                    if (cnt_q == LAST_CNT) begin
                        state_d     = ST_DONE;
                        res_fase_d  = acc_fase_d;
                        res_cuad_d  = acc_cuad_d;
                        res_valid_d = 1'b1;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_W'(1);
                end
            end

            ST_DONE, ST_ERROR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Flag outputs are registered copies of the state being entered.
        enable_d = (state_d == ST_RUN);
        clear_d  = (state_d == ST_CLEAR);
        busy_d   = (state_d == ST_CLEAR) || (state_d == ST_RUN);
        done_d   = (state_d == ST_DONE);
        error_d  = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_fase_q  <= '0;
            acc_cuad_q  <= '0;
            res_fase_q  <= '0;
            res_cuad_q  <= '0;
            cnt_q       <= '0;
            clr_cnt_q   <= '0;
            tmo_q       <= '0;
            res_valid_q <= 1'b0;
            enable_q    <= 1'b0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_fase_q  <= acc_fase_d;
            acc_cuad_q  <= acc_cuad_d;
            res_fase_q  <= res_fase_d;
            res_cuad_q  <= res_cuad_d;
            cnt_q       <= cnt_d;
            clr_cnt_q   <= clr_cnt_d;
            tmo_q       <= tmo_d;
            res_valid_q <= res_valid_d;
            enable_q    <= enable_d;
            clear_q     <= clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign enable_out = enable_q;
    assign clear_out  = clear_q;
    assign res_fase   = res_fase_q;
    assign res_cuad   = res_cuad_q;
    assign res_valid  = res_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_lockin_measurement_sequencer.sv
// Directed + randomized bench for the lock-in measurement sequencer; expected
// sums and flag sequences come from plain arithmetic over the fed samples.
module tb_lockin_measurement_sequencer;

    localparam int Q    = 50;
    localparam int LG   = 2;
    localparam int NR   = 4;
    localparam int CLRC = 4;
    localparam int TMO  = 16;
    localparam int W    = Q + LG;

    logic clk = 1'b0;
    logic reset, start, abort, li_valid;
    logic [Q-1:0] li_fase, li_cuad;
    logic enable_out, clear_out, res_valid, busy, done, error;
    logic [W-1:0] res_fase, res_cuad;

    int tests = 0;
    int fails = 0;

    logic signed [63:0] sum_f, sum_c, exp_res_f, exp_res_c;

    lockin_measurement_sequencer #(
        .Q_IN(Q), .N_RES(NR), .LOG2_N_RES(LG), .CLEAR_CYCLES(CLRC),
        .TIMEOUT(TMO), .TIMEOUT_W(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .li_valid(li_valid), .li_fase(li_fase), .li_cuad(li_cuad),
        .enable_out(enable_out), .clear_out(clear_out),
        .res_fase(res_fase), .res_cuad(res_cuad), .res_valid(res_valid),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input bit en, input bit clr,
                             input bit bsy, input bit dn, input bit err);
        chk({tag, ".enable"}, {63'd0, enable_out}, {63'd0, en});
        chk({tag, ".clear"},  {63'd0, clear_out},  {63'd0, clr});
        chk({tag, ".busy"},   {63'd0, busy},       {63'd0, bsy});
        chk({tag, ".done"},   {63'd0, done},       {63'd0, dn});
        chk({tag, ".error"},  {63'd0, error},      {63'd0, err});
    endtask

    task automatic chk_res(input string tag);
        chk({tag, ".res_fase"}, 64'($signed(res_fase)), exp_res_f);
        chk({tag, ".res_cuad"}, 64'($signed(res_cuad)), exp_res_c);
    endtask

    function automatic logic signed [63:0] rnd_q();
        logic [Q-1:0] r;
        r = Q'({$urandom(), $urandom()});
        return 64'($signed(r));
    endfunction

    task automatic scramble();
        li_fase = Q'(rnd_q());
        li_cuad = Q'(rnd_q());
    endtask

    // Pulse start from IDLE/DONE/ERROR and walk through the clear window.
    task automatic start_run(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < CLRC; i++) begin
            chk_flags({tag, ".clr"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk_flags({tag, ".run"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        sum_f = 0;
        sum_c = 0;
    endtask

    task automatic feed(input logic signed [63:0] f, input logic signed [63:0] c);
        li_valid = 1'b1;
        li_fase  = f[Q-1:0];
        li_cuad  = c[Q-1:0];
        sum_f    = sum_f + f;
        sum_c    = sum_c + c;
        tick();
        li_valid = 1'b0;
        scramble();
    endtask

    task automatic finish_check(input string tag);
        chk({tag, ".res_valid"}, {63'd0, res_valid}, 64'd1);
        chk_flags({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_res_f = sum_f;
        exp_res_c = sum_c;
        chk_res(tag);
        tick();
        chk({tag, ".pulse_end"}, {63'd0, res_valid}, 64'd0);
        chk({tag, ".done_held"}, {63'd0, done}, 64'd1);
    endtask

    task automatic rand_run(input string tag, input int max_gap);
        start_run(tag);
        for (int k = 0; k < NR; k++) begin
            int gap;
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk({tag, ".gap_rv"}, {63'd0, res_valid}, 64'd0);
                chk({tag, ".gap_en"}, {63'd0, enable_out}, 64'd1);
            end
            feed(rnd_q(), rnd_q());
        end
        finish_check(tag);
        $display("[TB] %s: sums fase=%0d cuad=%0d", tag, exp_res_f, exp_res_c);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; li_valid = 1'b0;
        li_fase = '0; li_cuad = '0;
        exp_res_f = 0; exp_res_c = 0; sum_f = 0; sum_c = 0;
        tick(); tick();
        chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.res_valid", {63'd0, res_valid}, 64'd0);
        chk_res("reset");
        reset = 1'b0;
        tick();
        chk_flags("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] reset: outputs zero");

        // Basic run with the documented values.
        start_run("basic");
        feed(100, 1); feed(200, 2); feed(-50, 3);
        chk("basic.no_early_done", {63'd0, done}, 64'd0);
        feed(10, 4);
        finish_check("basic");
        chk("basic.fase260", exp_res_f, 64'sd260);
        $display("[TB] basic: fase=%0d cuad=%0d", exp_res_f, exp_res_c);

        // Signed extremes.
        start_run("neg_ext");
        for (int i = 0; i < NR; i++) feed(-(64'sd1 <<< 49), -(64'sd1 <<< 49));
        finish_check("neg_ext");
        chk("neg_ext.exact", 64'($signed(res_fase)), -(64'sd1 <<< 51));
        $display("[TB] neg_ext: fase=%0d", exp_res_f);
        start_run("pos_ext");
        for (int i = 0; i < NR; i++) feed((64'sd1 <<< 49) - 1, (64'sd1 <<< 49) - 1);
        finish_check("pos_ext");
        chk("pos_ext.exact", 64'($signed(res_fase)), (64'sd1 <<< 51) - 4);
        $display("[TB] pos_ext: fase=%0d", exp_res_f);

        // Randomized runs with idle gaps well inside the timeout.
        for (int r = 0; r < 6; r++) rand_run($sformatf("rand%0d", r), 5);

        // Timeout: one valid then silence; error after the 15th idle cycle.
        start_run("tmo");
        feed(rnd_q(), rnd_q());
        for (int i = 1; i <= TMO - 1; i++) begin
            tick();
            chk("tmo.rv", {63'd0, res_valid}, 64'd0);
            if (i < TMO - 1) chk("tmo.err_early", {63'd0, error}, 64'd0);
        end
        chk_flags("tmo.err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_res("tmo.held");
        tick();
        chk("tmo.err_held", {63'd0, error}, 64'd1);
        $display("[TB] timeout: error raised, res held");

        // Valid on the expiry cycle is accepted; run then completes (start from ERROR).
        start_run("tmo_edge");
        feed(rnd_q(), rnd_q());
        for (int i = 1; i < TMO - 1; i++) tick();
        feed(rnd_q(), rnd_q());
        chk_flags("tmo_edge.alive", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        feed(rnd_q(), rnd_q());
        feed(rnd_q(), rnd_q());
        finish_check("tmo_edge");
        $display("[TB] timeout edge: valid accepted, no error");

        // Abort mid-run after two valids, then a fresh run.
        start_run("abort");
        feed(rnd_q(), rnd_q());
        feed(rnd_q(), rnd_q());
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_flags("abort.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort.rv", {63'd0, res_valid}, 64'd0);
        chk_res("abort.held");
        rand_run("after_abort", 2);

        // Start held through a whole run: no restart, DONE goes straight to CLEAR.
        start = 1'b1;
        tick();
        for (int i = 0; i < CLRC; i++) begin
            chk("held.clr", {63'd0, clear_out}, 64'd1);
            tick();
        end
        sum_f = 0; sum_c = 0;
        for (int k = 0; k < NR; k++) begin
            chk_flags("held.run", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            feed(rnd_q(), rnd_q());
        end
        chk({"held", ".res_valid"}, {63'd0, res_valid}, 64'd1);
        chk({"held", ".done"}, {63'd0, done}, 64'd1);
        exp_res_f = sum_f; exp_res_c = sum_c;
        chk_res("held");
        tick();
        chk_flags("held.reclear", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_flags("held.abort_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] held start: single clear per run");

        // li_valid in DONE is ignored; start+abort in DONE goes to IDLE.
        rand_run("done_ign", 1);
        li_valid = 1'b1;
        scramble();
        tick(); tick();
        li_valid = 1'b0;
        chk_res("done_ign.held");
        chk("done_ign.rv", {63'd0, res_valid}, 64'd0);
        chk("done_ign.done", {63'd0, done}, 64'd1);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_flags("start_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] start+abort in DONE: idle");

        // li_valid in IDLE is ignored.
        li_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            scramble();
            tick();
            chk("idle_ign.rv", {63'd0, res_valid}, 64'd0);
        end
        li_valid = 1'b0;
        chk_res("idle_ign.held");
        chk_flags("idle_ign", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] li_valid in idle ignored");

        // Reset mid-run clears everything including res_*.
        start_run("rst");
        feed(rnd_q(), rnd_q());
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_res_f = 0; exp_res_c = 0;
        chk_flags("rst.flags", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.rv", {63'd0, res_valid}, 64'd0);
        chk_res("rst");
        tick();
        chk_flags("rst.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] reset mid-run: outputs zero");

        // A run after reset still works.
        rand_run("post_rst", 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lockin_measurement_sequencer.md
Name: lockin_measurement_sequencer

Overview:
Sequences one complete lock-in measurement on the coherent-average + lock-in chain. It clears the datapath, asserts the stream enable, and collects N_RES consecutive lock-in results. It sums phase and quadrature, publishes the sums to the amplitude stage, and flags a timeout if the chain stalls. Sits between the control switches/keys and the data_source / coherent_average_sm / lockin enable inputs.

Parameters:
Q_IN, 50, width of lock-in phase/quadrature words (two's complement)
N_RES, 4, lock-in results accumulated per measurement (power of two, >=1)
LOG2_N_RES, 2, log2(N_RES); accumulator growth bits
CLEAR_CYCLES, 4, cycles clear_out is held before RUN (>=1)
TIMEOUT, 1048576, max cycles between successive li_valid in RUN
TIMEOUT_W, 21, width of timeout counter (holds TIMEOUT)

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request a measurement (level sampled each cycle)
abort  in  1  cancel current measurement / clear DONE or ERROR
li_valid  in  1  lock-in data_out_valid
li_fase  in  Q_IN  lock-in phase result, signed
li_cuad  in  Q_IN  lock-in quadrature result, signed
enable_out  out  1  stream enable to data source and coherent averager
clear_out  out  1  datapath clear
res_fase  out  Q_IN+LOG2_N_RES  accumulated phase, signed
res_cuad  out  Q_IN+LOG2_N_RES  accumulated quadrature, signed
res_valid  out  1  one-cycle pulse: res_* updated
busy  out  1  state is CLEAR or RUN
done  out  1  state is DONE
error  out  1  state is ERROR (timeout)

Behaviour:
- Reset (sync, active-high), dominates everything: state IDLE; all outputs 0, including res_fase/res_cuad. Accumulators, sample counter, clear counter and timeout counter are 0.
- States: IDLE, CLEAR, RUN, DONE, ERROR. All outputs are registered.
- Priority each cycle: reset > abort > li_valid > timeout > start.
- IDLE: start=1 moves to CLEAR next cycle.
- CLEAR: clear_out=1 and enable_out=0 for exactly CLEAR_CYCLES cycles. Accumulators, sample counter and timeout counter are zeroed. Then RUN.
- RUN: enable_out=1, clear_out=0.
  - On li_valid: accumulators get += sign-extended li_fase/li_cuad; count++; timeout counter cleared.
  - Without li_valid: timeout counter++.
  - The li_valid that makes count==N_RES leads to the next cycle: res_fase/res_cuad = full sums including that sample; res_valid=1 for one cycle; state DONE; enable_out=0.
- Timeout: if the counter reaches TIMEOUT-1 in RUN with no li_valid, the next cycle is ERROR with enable_out=0. If li_valid arrives on the expiry cycle, the valid is accepted and no error is raised.
- DONE: done=1 is held.
  - start moves to CLEAR (done drops when CLEAR is entered).
  - abort moves to IDLE.
- ERROR: error=1 is held.
  - start moves to CLEAR.
  - abort moves to IDLE.
  - res_* keep their previous values.
- abort in CLEAR or RUN: IDLE next cycle. enable_out and clear_out go 0, no res_valid, res_* unchanged.
- start while busy is ignored and never restarts the run.
- start and abort together: abort wins. From DONE or ERROR this goes to IDLE, not CLEAR.
- li_valid outside RUN is ignored.
- Arithmetic: no saturation. The Q_IN+LOG2_N_RES width is sufficient by construction.
- Latency: start to enable_out=1 is CLEAR_CYCLES+1 cycles. Last li_valid to res_valid is 1 cycle.

Test Plan:
- Basic run, N_RES=4: start pulse, then li_valid with fase=100,200,-50,10 and cuad=1,2,3,4 -> clear_out high for 4 cycles, then enable_out=1; res_fase=260, res_cuad=10; res_valid is a single pulse 1 cycle after the 4th valid; done=1, busy=0.
- Signed extremes: four li_fase=-2^49 -> res_fase=-2^51 exactly; second run with four 2^49-1 -> 2^51-4; no overflow.
- Timeout with TIMEOUT=16: start, one li_valid, then silence -> error=1 on the cycle after 15 idle cycles; enable_out=0; res_valid never pulses. Variant with li_valid on the expiry cycle -> no error.
- Abort mid-RUN after 2 valids -> IDLE next cycle, enable_out=0, res_* still hold the prior run's values. Then start -> fresh run whose sums exclude the aborted samples.
- Start while busy / simultaneous events: start held high through a whole run -> only one CLEAR per run, and DONE re-enters CLEAR on the next cycle. Start+abort in DONE -> IDLE.
- Reset mid-RUN (reset=1 for 1 cycle) -> all outputs 0 the next cycle and IDLE. li_valid during IDLE or DONE leaves res_* unchanged.
